// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage of the single-issue MIPS core.
//
// Holds the program counter, fetches one word per instruction from
// instruction memory over a req/ack handshake, latches it, exposes its
// bit-fields to the control decoder and computes the next PC from the
// decoder's jump/Branch outputs and the ALU zero flag.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   imem_req/addr     fetch request and byte address (= pc)
//   imem_ack/rdata    memory response, data valid with ack
//   jump, Branch,zero next-PC selection, sampled at the un-stalled EXEC edge
//   stall             holds the current instruction in EXEC
//   pc, pc_plus4      current instruction address and pc + 4
//   instr + fields    latched instruction and its decoded slices
//   instr_valid       high in EXEC
//   fault             sticky fetch-timeout flag (cleared only by rst)
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        jump,
  input  logic        Branch,
  input  logic        zero,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  OpCode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] target26,
  output logic        instr_valid,
  output logic        fault
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_FAULT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] pc_p4, br_off, pc_next;

  assign pc_p4  = pc_q + 32'd4;
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // jump beats branch; all arithmetic wraps modulo 2^32
  always_comb begin
    pc_next = pc_p4;
    if (jump)                pc_next = {pc_p4[31:28], instr_q[25:0], 2'b00};
    else if (Branch && zero) pc_next = pc_p4 + br_off;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        // an ack on the final count still wins over the timeout
        if (imem_ack) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pc_d    = pc_next;
          state_d = S_FETCH;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decode straight from state so rst drops them at once.
  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_EXEC);
  assign fault       = (state_q == S_FAULT);

  assign pc       = pc_q;
  assign pc_plus4 = pc_p4;
  assign instr    = instr_q;
  assign OpCode   = instr_q[31:26];
  assign rs       = instr_q[25:21];
  assign rt       = instr_q[20:16];
  assign rd       = instr_q[15:11];
  assign funct    = instr_q[5:0];
  assign imm16    = instr_q[15:0];
  assign target26 = instr_q[25:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        jump = 1'b0, Branch = 1'b0, zero = 1'b0, stall = 1'b0;
  logic [31:0] pc, pc_plus4, instr;
  logic [5:0]  OpCode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic        instr_valid, fault;

  int checks = 0, failures = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_instr[$];

  fetch_unit #(.PC_RESET(32'h0000_3000), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .jump(jump), .Branch(Branch),
    .zero(zero), .stall(stall), .pc(pc), .pc_plus4(pc_plus4), .instr(instr),
    .OpCode(OpCode), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm16(imm16),
    .target26(target26), .instr_valid(instr_valid), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: each new request must match the next expected address, each
  // entry into EXEC must present the next expected instruction word.
  logic prev_req = 1'b0, prev_vld = 1'b0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (imem_req && !prev_req) begin
      if (exp_addr.size() == 0) chk("unexpected_req", imem_addr, 32'hFFFF_FFFF);
      else begin e = exp_addr.pop_front(); chk("req_addr", imem_addr, e); end
    end
    if (instr_valid && !prev_vld) begin
      if (exp_instr.size() == 0) chk("unexpected_exec", instr, 32'hFFFF_FFFF);
      else begin
        e = exp_instr.pop_front();
        chk("exec_instr", instr, e);
        chk("exec_imm16", {16'h0, imm16}, {16'h0, e[15:0]});
        chk("exec_opcode", {26'h0, OpCode}, {26'h0, e[31:26]});
      end
    end
    prev_req = imem_req;
    prev_vld = instr_valid;
  end

  task automatic wait_req();
    for (int i = 0; i < 40 && !imem_req; i++) @(posedge clk) #1;
    if (!imem_req) chk("req_timeout", {31'h0, imem_req}, 32'h1);
  endtask

  // Serve one fetch: ack after `waits` cycles; ends in EXEC.
  task automatic fetch(input logic [31:0] a, input logic [31:0] w, input int waits);
    exp_addr.push_back(a);
    exp_instr.push_back(w);
    wait_req();
    repeat (waits) @(posedge clk) #1;
    imem_ack = 1'b1; imem_rdata = w;
    @(posedge clk) #1;
    imem_ack = 1'b0; imem_rdata = '0;
  endtask

  // Leave EXEC after `nstall` held cycles; stray acks during the stall.
  task automatic exec(input logic j, input logic b, input logic z, input int nstall);
    logic [31:0] pc0, in0;
    pc0 = pc; in0 = instr;
    jump = j; Branch = b; zero = z;
    if (nstall > 0) begin
      stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      repeat (nstall) begin
        @(posedge clk) #1;
        chk("stall_pc", pc, pc0);
        chk("stall_instr", instr, in0);
        chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      end
      stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    end
    @(posedge clk) #1;
    jump = 1'b0; Branch = 1'b0; zero = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk) #1;
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    rst = 1'b0;
    chk("idle_req", {31'h0, imem_req}, 32'h0);

    // sequential fetch, ori $1,$0,1
    fetch(32'h0000_3000, 32'h3401_0001, 0);
    chk("seq_valid", {31'h0, instr_valid}, 32'h1);
    chk("seq_opcode", {26'h0, OpCode}, 32'h0000_000D);
    chk("seq_rt", {27'h0, rt}, 32'h1);
    chk("seq_imm16", {16'h0, imm16}, 32'h1);
    chk("seq_pc_plus4", pc_plus4, 32'h0000_3004);
    exec(0, 0, 0, 0);

    // 3 wait cycles, then 3 stalled EXEC cycles
    fetch(32'h0000_3004, 32'h0022_1820, 3);
    chk("wait_rd", {27'h0, rd}, 32'h3);
    exec(0, 0, 0, 3);

    // beq taken back to 0x3004, then not taken to 0x300C
    fetch(32'h0000_3008, 32'h1000_FFFE, 0);
    exec(0, 1, 1, 0);
    fetch(32'h0000_3004, 32'h0022_1820, 0);
    exec(1'b0, 1'b0, 1'b1, 0);
    fetch(32'h0000_3008, 32'h1000_FFFE, 0);
    exec(0, 1, 0, 0);
    fetch(32'h0000_300C, 32'h0000_0000, 0);
    exec(0, 0, 0, 0);

    // jump wins over a simultaneous taken branch
    fetch(32'h0000_3010, 32'h0800_0C10, 0);
    chk("jmp_target26", {6'h0, target26}, 32'h0000_0C10);
    exec(1, 1, 1, 0);
    fetch(32'h0000_3040, 32'h0800_0000, 0);
    exec(1, 0, 0, 0);

    // backward branch from 0 wraps to 0xFFFF_FFFC, then +4 wraps to 0
    fetch(32'h0000_0000, 32'h1000_FFFE, 0);
    exec(0, 1, 1, 0);
    fetch(32'hFFFF_FFFC, 32'h0000_0000, 0);
    chk("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
    exec(0, 0, 0, 0);

    // ack on the last allowed wait cycle still completes
    fetch(32'h0000_0000, 32'h0000_0025, 15);
    chk("late_ack_valid", {31'h0, instr_valid}, 32'h1);
    chk("late_ack_fault", {31'h0, fault}, 32'h0);
    exec(0, 0, 0, 0);

    // timeout: 16 cycles without ack
    exp_addr.push_back(32'h0000_0004);
    wait_req();
    repeat (15) @(posedge clk) #1;
    chk("to_req_before", {31'h0, imem_req}, 32'h1);
    chk("to_fault_before", {31'h0, fault}, 32'h0);
    @(posedge clk) #1;
    chk("to_fault", {31'h0, fault}, 32'h1);
    chk("to_req", {31'h0, imem_req}, 32'h0);
    chk("to_valid", {31'h0, instr_valid}, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    repeat (3) @(posedge clk) #1;
    imem_ack = 1'b0; imem_rdata = '0;
    chk("to_sticky", {31'h0, fault}, 32'h1);
    rst = 1'b1;
    #1;
    chk("to_rst_fault", {31'h0, fault}, 32'h0);
    chk("to_rst_pc", pc, 32'h0000_3000);
    @(posedge clk) #1;
    rst = 1'b0;

    // reset during a pending fetch drops the request immediately
    exp_addr.push_back(32'h0000_3000);
    wait_req();
    @(posedge clk) #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_instr", instr, 32'h0);
    @(posedge clk) #1;
    rst = 1'b0;
    chk("mid_idle_req", {31'h0, imem_req}, 32'h0);
    fetch(32'h0000_3000, 32'h3401_0001, 0);
    exec(0, 0, 0, 0);
    exp_addr.push_back(32'h0000_3004);
    wait_req();

    repeat (2) @(posedge clk) #1;
    chk("addr_queue_empty", exp_addr.size(), 32'h0);
    chk("instr_queue_empty", exp_instr.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
